// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Stall/flush sequencer for the 5-stage core. It drives the en/flush pair of
// every stage register and the PC enable. A stage register with en=1 and
// flush=1 loads a NOP bubble.
//
// Hazards are resolved in this priority order, highest first:
//   1. data-memory freeze (mem_req & ~mem_ready): the whole pipe holds
//   2. multi-cycle divide: the front end holds and bubbles go into MEM until
//      div_done is seen
//   3. taken branch in EX: IF/ID and ID/EX are squashed
//   4. load-use: a one-cycle bubble goes into EX and the front end holds
//
// While the pipe is frozen, a watchdog counts consecutive freeze cycles and
// sets the sticky mem_timeout flag once MEM_TIMEOUT cycles have passed.
//
// Optional feature: define PIPE_PERF_CNT_EN to build the stall_cycles and
// flush_events performance counters. Without the macro, both ports read 0
// and no counter flops exist.
//
// Parameters:
//   REG_W        register index width
//   MEM_TIMEOUT  consecutive freeze cycles before mem_timeout sets (>= 1)
//
// Ports:
//   clk, rst_n              core clock, synchronous active-low reset
//   id_rs1/id_rs2           source indices of the instruction in ID
//   id_use_rs1/id_use_rs2   ID instruction actually reads that source
//   ex_rd                   destination index of the instruction in EX
//   ex_is_load/ex_is_div    EX instruction class
//   branch_taken            EX redirect
//   mem_req/mem_ready       MEM-stage data access handshake
//   div_done                one-cycle divider completion pulse
//   div_start               one-cycle divider launch pulse
//   pc_en                   PC register enable
//   *_en/*_flush            stage register controls
//   mem_timeout             sticky watchdog error
//   stall_cycles            cycles with pc_en=0 outside INIT
//   flush_events            RUN/DIV_WAIT cycles with any flush asserted
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_is_div,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             div_done,
    output logic             div_start,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_timeout,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
);

    // The counter must be able to hold MEM_TIMEOUT itself, because it
    // saturates at that value.
    localparam int unsigned     CntW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] WaitMax = CntW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StDivWait
    } state_e;

    state_e          state_q, state_d;
    logic            done_seen_q, done_seen_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic freeze;
    logic load_use;
    logic div_release;
    logic redirect_ok;

    assign freeze = mem_req & ~mem_ready;

    // A write to x0 never creates a dependency.
    assign load_use = ex_is_load & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    // A completion pulse that arrived while frozen is remembered in done_seen.
    assign div_release = done_seen_q | div_done;

    // -------------------------------------------------------------------------
    // Next state and stage controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        done_seen_d  = done_seen_q;
        redirect_ok  = 1'b0;

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_en    = 1'b1;
        div_start    = 1'b0;

        unique case (state_q)
            StInit: begin
                // Clock NOPs into every stage once while the PC holds.
                pc_en        = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                state_d      = StRun;
            end

            StRun: begin
                if (freeze) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                end else if (ex_is_div) begin
                    // The divide stays in EX. Only the MEM side keeps moving,
                    // and it receives bubbles.
                    div_start    = 1'b1;
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                    state_d      = StDivWait;
                end else begin
                    redirect_ok = 1'b1;
                end
            end

            StDivWait: begin
                if (freeze) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    if (div_done) begin
                        done_seen_d = 1'b1;
                    end
                end else if (!div_release) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                end else begin
                    // Release cycle. The divide leaves EX normally, and the
                    // younger instructions still see branch and load-use.
                    redirect_ok = 1'b1;
                    done_seen_d = 1'b0;
                    state_d     = StRun;
                end
            end

            default: begin
                state_d = StInit;
            end
        endcase

        if (redirect_ok) begin
            if (branch_taken) begin
                // The squashed ID instruction cannot cause a load-use stall.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory-wait watchdog
    // -------------------------------------------------------------------------
    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if ((state_q != StInit) && freeze) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d == WaitMax) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    assign mem_timeout = mem_timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StInit;
            done_seen_q   <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            done_seen_q   <= done_seen_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;
    logic        running;

    assign running = (state_q == StRun) || (state_q == StDivWait);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (running && !pc_en) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (running && (if_id_flush || id_ex_flush || ex_mem_flush)) begin
            flush_events_d = flush_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int unsigned RegW       = 5;
    localparam int unsigned MemTimeout = 64;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [RegW-1:0] id_rs1, id_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_is_load, ex_is_div, branch_taken;
    logic            mem_req, mem_ready, div_done;
    logic            div_start, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic            ex_mem_en, ex_mem_flush, mem_wb_en, mem_timeout;
    logic [31:0]     stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W      (RegW),
        .MEM_TIMEOUT(MemTimeout)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .ex_is_div   (ex_is_div),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .div_done    (div_done),
        .div_start   (div_start),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .id_ex_en    (id_ex_en),
        .id_ex_flush (id_ex_flush),
        .ex_mem_en   (ex_mem_en),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_en   (mem_wb_en),
        .mem_timeout (mem_timeout),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_en;
        logic        id_ex_flush;
        logic        ex_mem_en;
        logic        ex_mem_flush;
        logic        mem_wb_en;
        logic        div_start;
        logic        mem_timeout;
        logic [31:0] stall_cycles;
        logic [31:0] flush_events;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state, expressed in terms of pipeline behaviour.
    bit          m_known    = 1'b0;  // becomes 1 after the first reset edge
    bit          m_filling  = 1'b0;  // the first cycle after reset
    bit          m_in_div   = 1'b0;  // waiting for the divider to finish
    bit          m_done_pend = 1'b0; // completion arrived while frozen
    int unsigned m_frozen_run = 0;
    bit          m_timed_out = 1'b0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    task automatic model_step(input string tag);
        obs_t e;
        bit frz, dep, release_now, hold_front;
        frz = mem_req && !mem_ready;
        dep = ex_is_load && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

        e = '0;
        e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1; e.mem_wb_en = 1;
        e.mem_timeout  = m_timed_out;
        e.stall_cycles = PerfEn ? m_stall : 32'd0;
        e.flush_events = PerfEn ? m_flush : 32'd0;

        release_now = m_in_div && (m_done_pend || div_done);
        hold_front  = (m_in_div && !release_now) || (!m_in_div && ex_is_div);

        if (m_filling) begin
            e.pc_en = 0; e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1;
        end else if (frz) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0; e.mem_wb_en = 0;
        end else if (hold_front) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_flush = 1;
            e.div_start = !m_in_div;
        end else if (branch_taken) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
        end else if (dep) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
        end

        if (m_known) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end

        if (!rst_n) begin
            m_known = 1; m_filling = 1; m_in_div = 0; m_done_pend = 0;
            m_frozen_run = 0; m_timed_out = 0; m_stall = 0; m_flush = 0;
        end else if (m_filling) begin
            m_filling = 0;
            m_frozen_run = 0;
        end else begin
            if (!e.pc_en) m_stall++;
            if (e.if_id_flush || e.id_ex_flush || e.ex_mem_flush) m_flush++;
            if (frz) begin
                if (m_frozen_run < MemTimeout) m_frozen_run++;
                if (m_frozen_run == MemTimeout) m_timed_out = 1;
                if (m_in_div && div_done) m_done_pend = 1;
            end else begin
                m_frozen_run = 0;
                if (release_now) begin
                    m_in_div = 0; m_done_pend = 0;
                end else if (!m_in_div && ex_is_div) begin
                    m_in_div = 1;
                end
            end
        end
    endtask

    task automatic set_idle();
        rst_n = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
        ex_is_load = 0; ex_is_div = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
        div_done = 0;
    endtask

    task automatic tick(input string tag);
        model_step(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] flags(input obs_t o);
        return {o.pc_en, o.if_id_en, o.if_id_flush, o.id_ex_en, o.id_ex_flush,
                o.ex_mem_en, o.ex_mem_flush, o.mem_wb_en, o.div_start, o.mem_timeout};
    endfunction

    // Monitor: compares the DUT outputs in mid-cycle against the queued expectation.
    initial begin
        obs_t  e, a;
        string t;
        int    cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '0;
                a.pc_en = pc_en; a.if_id_en = if_id_en; a.if_id_flush = if_id_flush;
                a.id_ex_en = id_ex_en; a.id_ex_flush = id_ex_flush; a.ex_mem_en = ex_mem_en;
                a.ex_mem_flush = ex_mem_flush; a.mem_wb_en = mem_wb_en;
                a.div_start = div_start; a.mem_timeout = mem_timeout;
                a.stall_cycles = stall_cycles; a.flush_events = flush_events;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got pc,ifen,iffl,exen,exfl,mmen,mmfl,wben,ds,to=%b stall=%0d flush=%0d; expected %b stall=%0d flush=%0d",
                             t, cyc, flags(a), a.stall_cycles, a.flush_events,
                             flags(e), e.stall_cycles, e.flush_events);
                end
            end
        end
    end

    initial begin
        set_idle();
        rst_n = 0;
        tick("pre_reset");
        tick("reset");
        tick("reset");
        rst_n = 1;
        tick("init_fill");
        tick("run_first");

        // Load-use on rs1, then the x0 case, which must not stall.
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        tick("load_use");
        set_idle();
        tick("after_load_use");
        ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        tick("load_use_x0");
        set_idle();

        // Branch together with load-use.
        ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; branch_taken = 1;
        tick("branch_and_load_use");
        set_idle();

        // Divide whose completion arrives 10 cycles after launch.
        ex_is_div = 1;
        tick("div_launch");
        for (int i = 0; i < 9; i++) tick("div_wait");
        div_done = 1;
        tick("div_release");
        set_idle();
        tick("div_after");

        // Watchdog: 70 frozen cycles, then recovery.
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 70; i++) tick("freeze");
        mem_ready = 1;
        tick("freeze_done");
        set_idle();
        for (int i = 0; i < 3; i++) tick("timeout_sticky");

        // Reset in the middle of a divide stall.
        ex_is_div = 1;
        tick("div_launch2");
        for (int i = 0; i < 2; i++) tick("div_wait2");
        rst_n = 0;
        tick("reset_mid_div");
        tick("reset_mid_div");
        set_idle();
        tick("init_after_div_reset");
        for (int i = 0; i < 4; i++) tick("no_reissue");

        // A completion pulse that arrives while the pipe is frozen.
        ex_is_div = 1;
        tick("div_launch3");
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 2; i++) tick("div_freeze");
        div_done = 1;
        tick("div_done_frozen");
        div_done = 0;
        for (int i = 0; i < 3; i++) tick("div_freeze_hold");
        mem_req = 0;
        tick("div_frozen_release");
        set_idle();
        tick("after_frozen_release");

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            id_rs1       = RegW'($urandom_range(0, 3));
            id_rs2       = RegW'($urandom_range(0, 3));
            ex_rd        = RegW'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_is_div    = ($urandom_range(0, 11) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = 1'($urandom_range(0, 1));
            div_done     = ($urandom_range(0, 5) == 0);
            tick("random");
        end

        set_idle();
        tick("final");
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
